// File: rtl/vdac_output_stage_if.sv
// Pixel-source and VDAC/VGA signal bundle for vdac_output_stage.
// The stage itself takes the slave view; board logic/benches take the master view.
interface vdac_output_stage_if #(
    parameter int unsigned IN_BITS  = 5,
    parameter int unsigned OUT_BITS = 8
);
    logic                src_sel_i;

    logic                a_pix_en_i;
    logic [IN_BITS-1:0]  a_red_i;
    logic [IN_BITS-1:0]  a_green_i;
    logic [IN_BITS-1:0]  a_blue_i;
    logic                a_hsync_i;
    logic                a_vsync_i;
    logic                a_blank_i;

    logic                b_pix_en_i;
    logic [IN_BITS-1:0]  b_red_i;
    logic [IN_BITS-1:0]  b_green_i;
    logic [IN_BITS-1:0]  b_blue_i;
    logic                b_hsync_i;
    logic                b_vsync_i;
    logic                b_blank_i;

    logic [OUT_BITS-1:0] red_o;
    logic [OUT_BITS-1:0] green_o;
    logic [OUT_BITS-1:0] blue_o;
    logic                hs_o;
    logic                vs_o;
    logic                sync_n_o;
    logic                blank_n_o;
    logic                psave_n_o;
    logic                active_src_o;
    logic                video_ok_o;

    modport master (
        output src_sel_i,
        output a_pix_en_i, a_red_i, a_green_i, a_blue_i, a_hsync_i, a_vsync_i, a_blank_i,
        output b_pix_en_i, b_red_i, b_green_i, b_blue_i, b_hsync_i, b_vsync_i, b_blank_i,
        input  red_o, green_o, blue_o, hs_o, vs_o, sync_n_o, blank_n_o, psave_n_o,
        input  active_src_o, video_ok_o
    );

    modport slave (
        input  src_sel_i,
        input  a_pix_en_i, a_red_i, a_green_i, a_blue_i, a_hsync_i, a_vsync_i, a_blank_i,
        input  b_pix_en_i, b_red_i, b_green_i, b_blue_i, b_hsync_i, b_vsync_i, b_blank_i,
        output red_o, green_o, blue_o, hs_o, vs_o, sync_n_o, blank_n_o, psave_n_o,
        output active_src_o, video_ok_o
    );
endinterface

// File: rtl/vdac_output_stage.sv
// VDAC/VGA output formatter: frame-gated A/B source select, colour expansion,
// sync polarity, blanking and a vsync watchdog driving power-save.
module vdac_output_stage #(
    parameter int unsigned IN_BITS         = 5,
    parameter int unsigned OUT_BITS        = 8,
    parameter bit          EXPAND_MODE     = 1'b1,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned TIMEOUT         = 1000000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    vdac_output_stage_if.slave vif
);
    localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned PAD      = OUT_BITS - IN_BITS;
    localparam int unsigned REP      = (OUT_BITS + IN_BITS - 1) / IN_BITS;
    localparam int unsigned REP_W    = REP * IN_BITS;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic        SYNC_OFF = SYNC_ACTIVE_LOW;

    typedef enum logic {
        VID_LOST = 1'b0,
        VID_OK   = 1'b1
    } vid_state_t;

    typedef struct packed {
        logic [IN_BITS-1:0] red;
        logic [IN_BITS-1:0] green;
        logic [IN_BITS-1:0] blue;
        logic               hsync;
        logic               vsync;
        logic               blank;
    } pix_t;

    // Widen one colour channel: zero-fill or MSB-first replication.
    function automatic logic [OUT_BITS-1:0] expand(input logic [IN_BITS-1:0] c);
        logic [REP_W-1:0]    rep;
        logic [OUT_BITS-1:0] r;
        rep = {REP{c}};
        if (EXPAND_MODE) r = rep[REP_W-1 -: OUT_BITS];
        else             r = OUT_BITS'(c) << PAD;
        return r;
    endfunction

    // State registers and their next values
    vid_state_t          vid_q,      vid_d;
    logic [CNT_W-1:0]    wd_cnt_q,   wd_cnt_d;
    logic                active_q,   active_d;
    logic                prev_a_q,   prev_a_d;
    logic                prev_b_q,   prev_b_d;
    logic [OUT_BITS-1:0] red_q,      red_d;
    logic [OUT_BITS-1:0] green_q,    green_d;
    logic [OUT_BITS-1:0] blue_q,     blue_d;
    logic                hs_q,       hs_d;
    logic                vs_q,       vs_d;
    logic                sync_n_q,   sync_n_d;
    logic                blank_n_q,  blank_n_d;
    logic                psave_n_q,  psave_n_d;

    pix_t                pix_a_c, pix_b_c, act_pix_c;
    logic                edge_a_c, edge_b_c, edge_act_c;
    logic                act_en_c, switch_pend_c, force_c;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vid_q     <= VID_LOST;
            wd_cnt_q  <= '0;
            active_q  <= 1'b0;
            prev_a_q  <= 1'b0;
            prev_b_q  <= 1'b0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
            hs_q      <= SYNC_OFF;
            vs_q      <= SYNC_OFF;
            sync_n_q  <= 1'b1;
            blank_n_q <= 1'b0;
            psave_n_q <= 1'b0;
        end else begin
            vid_q     <= vid_d;
            wd_cnt_q  <= wd_cnt_d;
            active_q  <= active_d;
            prev_a_q  <= prev_a_d;
            prev_b_q  <= prev_b_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            sync_n_q  <= sync_n_d;
            blank_n_q <= blank_n_d;
            psave_n_q <= psave_n_d;
        end
    end

    always_comb begin
        vid_d     = vid_q;
        wd_cnt_d  = wd_cnt_q;
        active_d  = active_q;
        prev_a_d  = prev_a_q;
        prev_b_d  = prev_b_q;
        red_d     = red_q;
        green_d   = green_q;
        blue_d    = blue_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        sync_n_d  = sync_n_q;
        blank_n_d = blank_n_q;
        psave_n_d = psave_n_q;

        pix_a_c = {vif.a_red_i, vif.a_green_i, vif.a_blue_i,
                   vif.a_hsync_i, vif.a_vsync_i, vif.a_blank_i};
        pix_b_c = {vif.b_red_i, vif.b_green_i, vif.b_blue_i,
                   vif.b_hsync_i, vif.b_vsync_i, vif.b_blank_i};

        // Vsync rising edges are tracked on both sources regardless of selection
        edge_a_c = vif.a_pix_en_i & vif.a_vsync_i & ~prev_a_q;
        edge_b_c = vif.b_pix_en_i & vif.b_vsync_i & ~prev_b_q;
        if (vif.a_pix_en_i) prev_a_d = vif.a_vsync_i;
        if (vif.b_pix_en_i) prev_b_d = vif.b_vsync_i;

        act_pix_c     = active_q ? pix_b_c : pix_a_c;
        act_en_c      = active_q ? vif.b_pix_en_i : vif.a_pix_en_i;
        edge_act_c    = active_q ? edge_b_c : edge_a_c;
        switch_pend_c = (vif.src_sel_i != active_q);

        // Watchdog: saturating count, cleared by any active-source frame start
        if (edge_act_c)                wd_cnt_d = '0;
        else if (wd_cnt_q != CNT_MAX)  wd_cnt_d = wd_cnt_q + CNT_W'(1);

        if (edge_act_c)                vid_d = VID_OK;
        else if (wd_cnt_d == CNT_MAX)  vid_d = VID_LOST;

        // Switch only on a frame boundary of the source being left
        if (edge_act_c && switch_pend_c) active_d = ~active_q;

        // A recovering edge releases the forced state in the same cycle it lands
        force_c = (vid_q == VID_LOST) && !edge_act_c;

        if (force_c) begin
            red_d     = '0;
            green_d   = '0;
            blue_d    = '0;
            hs_d      = SYNC_OFF;
            vs_d      = SYNC_OFF;
            sync_n_d  = 1'b1;
            blank_n_d = 1'b0;
            psave_n_d = 1'b0;
        end else begin
            psave_n_d = 1'b1;
            if (act_en_c) begin
                red_d     = act_pix_c.blank ? '0 : expand(act_pix_c.red);
                green_d   = act_pix_c.blank ? '0 : expand(act_pix_c.green);
                blue_d    = act_pix_c.blank ? '0 : expand(act_pix_c.blue);
                hs_d      = act_pix_c.hsync ^ SYNC_OFF;
                vs_d      = act_pix_c.vsync ^ SYNC_OFF;
                sync_n_d  = ~(act_pix_c.hsync | act_pix_c.vsync);
                blank_n_d = ~act_pix_c.blank;
            end
        end
    end

    assign vif.red_o        = red_q;
    assign vif.green_o      = green_q;
    assign vif.blue_o       = blue_q;
    assign vif.hs_o         = hs_q;
    assign vif.vs_o         = vs_q;
    assign vif.sync_n_o     = sync_n_q;
    assign vif.blank_n_o    = blank_n_q;
    assign vif.psave_n_o    = psave_n_q;
    assign vif.active_src_o = active_q;
    assign vif.video_ok_o   = (vid_q == VID_OK);
endmodule

// File: tb/tb_vdac_output_stage.sv
// Randomized bench for vdac_output_stage: three configurations share one stimulus
// stream and are compared every cycle against a frame-level reference model.
module tb_vdac_output_stage;
    localparam int unsigned TO = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared stimulus; the 5-bit instances see the low bits of each colour
    logic       sel;
    logic       a_en, a_hs, a_vs, a_bl;
    logic [7:0] a_r, a_g, a_b;
    logic       b_en, b_hs, b_vs, b_bl;
    logic [7:0] b_r, b_g, b_b;

    vdac_output_stage_if #(.IN_BITS(5), .OUT_BITS(8)) if0 ();
    vdac_output_stage_if #(.IN_BITS(5), .OUT_BITS(8)) if1 ();
    vdac_output_stage_if #(.IN_BITS(8), .OUT_BITS(8)) if2 ();

    assign if0.src_sel_i = sel;  assign if1.src_sel_i = sel;  assign if2.src_sel_i = sel;
    assign if0.a_pix_en_i = a_en; assign if1.a_pix_en_i = a_en; assign if2.a_pix_en_i = a_en;
    assign if0.b_pix_en_i = b_en; assign if1.b_pix_en_i = b_en; assign if2.b_pix_en_i = b_en;
    assign if0.a_hsync_i = a_hs; assign if1.a_hsync_i = a_hs; assign if2.a_hsync_i = a_hs;
    assign if0.a_vsync_i = a_vs; assign if1.a_vsync_i = a_vs; assign if2.a_vsync_i = a_vs;
    assign if0.a_blank_i = a_bl; assign if1.a_blank_i = a_bl; assign if2.a_blank_i = a_bl;
    assign if0.b_hsync_i = b_hs; assign if1.b_hsync_i = b_hs; assign if2.b_hsync_i = b_hs;
    assign if0.b_vsync_i = b_vs; assign if1.b_vsync_i = b_vs; assign if2.b_vsync_i = b_vs;
    assign if0.b_blank_i = b_bl; assign if1.b_blank_i = b_bl; assign if2.b_blank_i = b_bl;
    assign if0.a_red_i = a_r[4:0]; assign if1.a_red_i = a_r[4:0]; assign if2.a_red_i = a_r;
    assign if0.a_green_i = a_g[4:0]; assign if1.a_green_i = a_g[4:0]; assign if2.a_green_i = a_g;
    assign if0.a_blue_i = a_b[4:0]; assign if1.a_blue_i = a_b[4:0]; assign if2.a_blue_i = a_b;
    assign if0.b_red_i = b_r[4:0]; assign if1.b_red_i = b_r[4:0]; assign if2.b_red_i = b_r;
    assign if0.b_green_i = b_g[4:0]; assign if1.b_green_i = b_g[4:0]; assign if2.b_green_i = b_g;
    assign if0.b_blue_i = b_b[4:0]; assign if1.b_blue_i = b_b[4:0]; assign if2.b_blue_i = b_b;

    vdac_output_stage #(.IN_BITS(5), .OUT_BITS(8), .EXPAND_MODE(1'b1), .SYNC_ACTIVE_LOW(1'b1),
                        .TIMEOUT(TO)) u0 (.clk_i(clk), .rst_i(rst), .vif(if0.slave));
    vdac_output_stage #(.IN_BITS(5), .OUT_BITS(8), .EXPAND_MODE(1'b0), .SYNC_ACTIVE_LOW(1'b0),
                        .TIMEOUT(TO)) u1 (.clk_i(clk), .rst_i(rst), .vif(if1.slave));
    vdac_output_stage #(.IN_BITS(8), .OUT_BITS(8), .EXPAND_MODE(1'b1), .SYNC_ACTIVE_LOW(1'b1),
                        .TIMEOUT(TO)) u2 (.clk_i(clk), .rst_i(rst), .vif(if2.slave));

    logic [7:0] got_red[3], got_grn[3], got_blu[3];
    logic       got_hs[3], got_vs[3], got_syn[3], got_bln[3], got_ps[3], got_act[3], got_ok[3];
    assign got_red[0] = if0.red_o;   assign got_red[1] = if1.red_o;   assign got_red[2] = if2.red_o;
    assign got_grn[0] = if0.green_o; assign got_grn[1] = if1.green_o; assign got_grn[2] = if2.green_o;
    assign got_blu[0] = if0.blue_o;  assign got_blu[1] = if1.blue_o;  assign got_blu[2] = if2.blue_o;
    assign got_hs[0] = if0.hs_o;     assign got_hs[1] = if1.hs_o;     assign got_hs[2] = if2.hs_o;
    assign got_vs[0] = if0.vs_o;     assign got_vs[1] = if1.vs_o;     assign got_vs[2] = if2.vs_o;
    assign got_syn[0] = if0.sync_n_o;  assign got_syn[1] = if1.sync_n_o;  assign got_syn[2] = if2.sync_n_o;
    assign got_bln[0] = if0.blank_n_o; assign got_bln[1] = if1.blank_n_o; assign got_bln[2] = if2.blank_n_o;
    assign got_ps[0] = if0.psave_n_o;  assign got_ps[1] = if1.psave_n_o;  assign got_ps[2] = if2.psave_n_o;
    assign got_act[0] = if0.active_src_o; assign got_act[1] = if1.active_src_o; assign got_act[2] = if2.active_src_o;
    assign got_ok[0] = if0.video_ok_o;    assign got_ok[1] = if1.video_ok_o;    assign got_ok[2] = if2.video_ok_o;

    // Per-instance configuration seen by the reference model
    int cfg_in[3]  = '{5, 5, 8};
    bit cfg_rep[3] = '{1'b1, 1'b0, 1'b1};
    bit cfg_sal[3] = '{1'b1, 1'b0, 1'b1};

    // Reference model state
    bit         m_act, m_lost, m_pa, m_pb;
    int         m_cnt;
    logic [7:0] e_red[3], e_grn[3], e_blu[3];
    bit         e_hs[3], e_vs[3], e_syn[3], e_bln[3], e_ps[3];

    int n_checks = 0;
    int n_errors = 0;
    int ph = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Widen a colour to 8 bits: shift up, or concatenate copies and keep the top 8
    function automatic int widen(input int v, input int inb, input bit rep);
        int acc = 0;
        int n = 0;
        v = v & ((1 << inb) - 1);
        if (!rep) return v << (8 - inb);
        while (n < 8) begin
            acc = (acc << inb) | v;
            n += inb;
        end
        return (acc >> (n - 8)) & 255;
    endfunction

    task automatic model_reset();
        m_act = 0; m_lost = 1; m_pa = 0; m_pb = 0; m_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            e_red[i] = 0; e_grn[i] = 0; e_blu[i] = 0;
            e_hs[i] = cfg_sal[i]; e_vs[i] = cfg_sal[i];
            e_syn[i] = 1; e_bln[i] = 0; e_ps[i] = 0;
        end
    endtask

    // One pixel-clock edge of the reference, from the input values held across it
    task automatic model_step();
        bit ea, eb, e, en, hs, vs, bl;
        int r, g, b;
        ea = a_en && a_vs && !m_pa;
        eb = b_en && b_vs && !m_pb;
        e  = m_act ? eb : ea;
        en = m_act ? b_en : a_en;
        if (m_act) begin r = b_r; g = b_g; b = b_b; hs = b_hs; vs = b_vs; bl = b_bl; end
        else       begin r = a_r; g = a_g; b = a_b; hs = a_hs; vs = a_vs; bl = a_bl; end
        for (int i = 0; i < 3; i++) begin
            if (m_lost && !e) begin
                e_red[i] = 0; e_grn[i] = 0; e_blu[i] = 0;
                e_hs[i] = cfg_sal[i]; e_vs[i] = cfg_sal[i];
                e_syn[i] = 1; e_bln[i] = 0; e_ps[i] = 0;
            end else begin
                e_ps[i] = 1;
                if (en) begin
                    e_red[i] = bl ? 8'd0 : 8'(widen(r, cfg_in[i], cfg_rep[i]));
                    e_grn[i] = bl ? 8'd0 : 8'(widen(g, cfg_in[i], cfg_rep[i]));
                    e_blu[i] = bl ? 8'd0 : 8'(widen(b, cfg_in[i], cfg_rep[i]));
                    e_hs[i]  = hs ^ cfg_sal[i];
                    e_vs[i]  = vs ^ cfg_sal[i];
                    e_syn[i] = !(hs || vs);
                    e_bln[i] = !bl;
                end
            end
        end
        if (e) begin
            m_cnt = 0;
            m_lost = 0;
            if (sel != m_act) m_act = !m_act;
        end else begin
            if (m_cnt < TO) m_cnt++;
            if (m_cnt == TO) m_lost = 1;
        end
        if (a_en) m_pa = a_vs;
        if (b_en) m_pb = b_vs;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d_red", i),     got_red[i], e_red[i]);
            check($sformatf("u%0d_green", i),   got_grn[i], e_grn[i]);
            check($sformatf("u%0d_blue", i),    got_blu[i], e_blu[i]);
            check($sformatf("u%0d_hs", i),      got_hs[i],  e_hs[i]);
            check($sformatf("u%0d_vs", i),      got_vs[i],  e_vs[i]);
            check($sformatf("u%0d_sync_n", i),  got_syn[i], e_syn[i]);
            check($sformatf("u%0d_blank_n", i), got_bln[i], e_bln[i]);
            check($sformatf("u%0d_psave_n", i), got_ps[i],  e_ps[i]);
            check($sformatf("u%0d_active", i),  got_act[i], m_act);
            check($sformatf("u%0d_video_ok", i), got_ok[i], !m_lost);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        sel = 0;
        a_en = 0; a_hs = 0; a_vs = 0; a_bl = 0; a_r = 0; a_g = 0; a_b = 0;
        b_en = 0; b_hs = 0; b_vs = 0; b_bl = 0; b_r = 0; b_g = 0; b_b = 0;
    endtask

    task automatic drive_rand(input bit a_live, input bit b_live, input bit sel_rand);
        ph++;
        a_en = ($urandom_range(0, 3) != 0);
        a_r = 8'($urandom); a_g = 8'($urandom); a_b = 8'($urandom);
        a_hs = ($urandom_range(0, 7) == 0);
        a_bl = ($urandom_range(0, 5) == 0);
        a_vs = a_live && ((ph % 24) < 3);
        b_en = ($urandom_range(0, 3) != 0);
        b_r = 8'($urandom); b_g = 8'($urandom); b_b = 8'($urandom);
        b_hs = ($urandom_range(0, 7) == 0);
        b_bl = ($urandom_range(0, 5) == 0);
        b_vs = b_live && ((ph % 31) < 4);
        if (sel_rand && $urandom_range(0, 29) == 0) sel = ~sel;
    endtask

    // Lost after reset until A's first frame, then known-colour spot checks
    task automatic first_frame();
        idle_inputs();
        a_en = 1; a_r = 8'hB6;
        for (int k = 0; k < 4; k++) tick();
        check("pre_edge_psave_n", if0.psave_n_o, 1'b0);
        check("pre_edge_hs_inactive", if0.hs_o, 1'b1);
        check("pre_edge_red_forced", if0.red_o, 8'h00);
        a_vs = 1; a_hs = 1;
        tick();
        check("edge_video_ok", if0.video_ok_o, 1'b1);
        check("edge_psave_n", if0.psave_n_o, 1'b1);
        check("red_replicate", if0.red_o, 8'hB5);
        check("red_zero_fill", if1.red_o, 8'hB0);
        check("red_passthru", if2.red_o, 8'hB6);
        check("hs_active_low", if0.hs_o, 1'b0);
        check("hs_active_high", if1.hs_o, 1'b1);
        check("sync_n_low", if0.sync_n_o, 1'b0);
        a_bl = 1; a_hs = 0;
        tick();
        check("blank_red", if0.red_o, 8'h00);
        check("blank_n_low", if0.blank_n_o, 1'b0);
        a_bl = 0; a_vs = 0;
        tick();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        model_reset();
        tick();
        tick();
        rst = 0;
        first_frame();

        // Randomized frames from both sources with occasional source requests
        for (int k = 0; k < 600; k++) begin drive_rand(1, 1, 1); tick(); end

        // Short request that is withdrawn before any frame boundary
        sel = ~if0.active_src_o;
        drive_rand(1, 1, 0); a_vs = 0; b_vs = 0; tick();
        sel = ~sel;
        for (int k = 0; k < 40; k++) begin drive_rand(1, 1, 0); tick(); end

        // All frames stop long enough to trip the watchdog, then resume
        for (int k = 0; k < 100; k++) begin drive_rand(0, 0, 0); tick(); end
        for (int k = 0; k < 100; k++) begin drive_rand(1, 1, 0); tick(); end

        // Request B while B is dead: the stage sticks on a silent source
        sel = 1;
        for (int k = 0; k < 200; k++) begin drive_rand(1, 0, 0); tick(); end
        sel = 0;
        for (int k = 0; k < 80; k++) begin drive_rand(1, 0, 0); tick(); end
        for (int k = 0; k < 150; k++) begin drive_rand(1, 1, 1); tick(); end

        // Asynchronous reset between clock edges
        @(posedge clk);
        model_step();
        #2 rst = 1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        tick();
        tick();
        rst = 0;
        first_frame();
        for (int k = 0; k < 200; k++) begin drive_rand(1, 1, 1); tick(); end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
